fp_addsub_compare_buffered: RTL and testbench

Digit-serial modular add/subtract unit for the Fp datapath: the successor of the add-and-compare block, generalised with an add/sub mode, a runtime constant and an output correction stage. It consumes operands a, b and a constant c (normally 2p) least-significant digit first, one RADIX-bit digit per valid beat. It computes a±b and the corrected candidate in parallel and buffers both. It then streams out the reduced result (a+b−c if a+b≥c, else a+b; a−b+c if a<b, else a−b).

---
 rtl/fp_addsub_compare_buffered.sv | 193 +++++++++++++++++++
 tb/tb_fp_addsub_compare_buffered.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_compare_buffered.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_compare_buffered
// Purpose  : Digit-serial modular add/subtract unit for the Fp datapath.
//            Operands a, b and a constant c (normally 2p) arrive LSD first,
//            one RADIX-bit digit per valid beat. The unit forms a+/-b (S)
//            and the corrected candidate (T = S-c for add, S+c for sub) in
//            parallel, buffers both, then streams the reduced result.
// Ports    : clk, rst                    - clock, synchronous active-high reset
//            start, mode, carry_in       - operation launch (mode 0 add, 1 sub)
//            digit_in_valid, digit_a/b/const - operand digit stream
//            digit_out_valid, digit_res  - result digit stream
//            a_plus_b_bigger_than_const  - correction applied flag
//            carry_out                   - final carry/borrow of a+/-b
//            done                        - pulse after the last output digit
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_compare_buffered #(
    parameter int RADIX  = 32,
    parameter int DIGITS = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             carry_in,
    input  logic             digit_in_valid,
    input  logic [RADIX-1:0] digit_a,
    input  logic [RADIX-1:0] digit_b,
    input  logic [RADIX-1:0] digit_const,
    output logic             digit_out_valid,
    output logic [RADIX-1:0] digit_res,
    output logic             a_plus_b_bigger_than_const,
    output logic             carry_out,
    output logic             done
);

    // Counter spans 0..DIGITS (DIGITS marks "all output digits issued");
    // buffer index uses only the low bits.
    localparam int c_CNT_W = $clog2(DIGITS + 1);
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST_IN = c_CNT_W'(DIGITS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_END     = c_CNT_W'(DIGITS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_ZERO    = '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SELECT = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic               r_mode;
    logic               r_chain1;     // stage-1 carry (add) / borrow (sub)
    logic               r_chain2;     // stage-2 borrow (add) / carry (sub)
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_use_t;
    logic               r_flag;
    logic               r_carry_out;
    logic [RADIX-1:0]   r_dout;
    logic               r_dout_valid;
    logic               r_done;

    logic [RADIX-1:0]   r_buf_s [DIGITS];
    logic [RADIX-1:0]   r_buf_t [DIGITS];

    logic [RADIX:0]     w_s1;
    logic [RADIX-1:0]   w_s;
    logic [RADIX:0]     w_t2;
    logic               w_flag;
    logic               w_accept;
    logic [c_IDX_W-1:0] w_idx;

    assign w_accept = (r_state == S_LOAD) && digit_in_valid;
    assign w_idx    = r_cnt[c_IDX_W-1:0];

    // Both stages use one extra bit: the MSB is the carry (sum) or the
    // borrow (difference, negative result in two's complement).
    always_comb begin
        w_s1 = '0;
        w_t2 = '0;
        if (!r_mode) begin
            w_s1 = {1'b0, digit_a} + {1'b0, digit_b} + {{RADIX{1'b0}}, r_chain1};
        end else begin
            w_s1 = {1'b0, digit_a} - {1'b0, digit_b} - {{RADIX{1'b0}}, r_chain1};
        end
        w_s = w_s1[RADIX-1:0];
        if (!r_mode) begin
            w_t2 = {1'b0, w_s} - {1'b0, digit_const} - {{RADIX{1'b0}}, r_chain2};
        end else begin
            w_t2 = {1'b0, w_s} + {1'b0, digit_const} + {{RADIX{1'b0}}, r_chain2};
        end
    end

    // Add: a+b >= c when the sum overflowed or S-c did not borrow.
    // Sub: correction whenever a-b borrowed.
    assign w_flag = r_mode ? r_chain1 : (r_chain1 | ~r_chain2);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_LOAD;
            S_LOAD:   if (w_accept && (r_cnt == c_CNT_LAST_IN)) w_state_next = S_SELECT;
            S_SELECT: w_state_next = S_OUT;
            S_OUT:    if (r_cnt == c_CNT_END) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Digit buffers carry no reset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf_s[w_idx] <= w_s;
            r_buf_t[w_idx] <= w_t2[RADIX-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode       <= 1'b0;
            r_chain1     <= 1'b0;
            r_chain2     <= 1'b0;
            r_cnt        <= '0;
            r_use_t      <= 1'b0;
            r_flag       <= 1'b0;
            r_carry_out  <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode      <= mode;
                        r_chain1    <= carry_in;
                        r_chain2    <= 1'b0;
                        r_cnt       <= '0;
                        r_flag      <= 1'b0;
                        r_carry_out <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_chain1 <= w_s1[RADIX];
                        r_chain2 <= w_t2[RADIX];
                        r_cnt    <= r_cnt + c_CNT_ONE;
                    end
                end
                S_SELECT: begin
                    // Digit 0 is issued here so output starts the next cycle.
                    r_flag       <= w_flag;
                    r_carry_out  <= r_chain1;
                    r_use_t      <= w_flag;
                    r_dout       <= w_flag ? r_buf_t[c_IDX_ZERO] : r_buf_s[c_IDX_ZERO];
                    r_dout_valid <= 1'b1;
                    r_cnt        <= c_CNT_ONE;
                end
                S_OUT: begin
                    if (r_cnt == c_CNT_END) begin
                        r_dout_valid <= 1'b0;
                        r_done       <= 1'b1;
                        r_cnt        <= '0;
                    end else begin
                        r_dout <= r_use_t ? r_buf_t[w_idx] : r_buf_s[w_idx];
                        r_cnt  <= r_cnt + c_CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign digit_out_valid            = r_dout_valid;
    assign digit_res                  = r_dout;
    assign a_plus_b_bigger_than_const = r_flag;
    assign carry_out                  = r_carry_out;
    assign done                       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_compare_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_compare_buffered
// Purpose  : Self-checking bench for fp_addsub_compare_buffered with
//            RADIX=8, DIGITS=4. Expected digits come from a whole-word model
//            and are queued when operands are driven; a monitor pops them
//            as result digits appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_compare_buffered;

    localparam int RADIX  = 8;
    localparam int DIGITS = 4;
    localparam int c_W    = RADIX * DIGITS;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode;
    logic             carry_in;
    logic             digit_in_valid;
    logic [RADIX-1:0] digit_a;
    logic [RADIX-1:0] digit_b;
    logic [RADIX-1:0] digit_const;
    logic             digit_out_valid;
    logic [RADIX-1:0] digit_res;
    logic             flag;
    logic             carry_out;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    logic [RADIX-1:0] exp_q[$];

    fp_addsub_compare_buffered #(
        .RADIX (RADIX),
        .DIGITS(DIGITS)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .mode                      (mode),
        .carry_in                  (carry_in),
        .digit_in_valid            (digit_in_valid),
        .digit_a                   (digit_a),
        .digit_b                   (digit_b),
        .digit_const               (digit_const),
        .digit_out_valid           (digit_out_valid),
        .digit_res                 (digit_res),
        .a_plus_b_bigger_than_const(flag),
        .carry_out                 (carry_out),
        .done                      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Result-digit scoreboard.
    always @(negedge clk) begin
        if (digit_out_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL digit_unexpected: got %02h, expected no output", digit_res);
            end else begin
                logic [RADIX-1:0] e;
                e = exp_q.pop_front();
                if (digit_res !== e) begin
                    n_errors++;
                    $display("FAIL digit_res: got %02h, expected %02h", digit_res, e);
                end
            end
        end
    end

    // Whole-word reference: reduced result, correction flag, stage-1 carry/borrow.
    function automatic void model(input logic m, input logic cin,
                                  input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                                  input logic [c_W-1:0] c,
                                  output logic [c_W-1:0] res, output logic f,
                                  output logic co);
        logic [c_W:0] wide;
        if (!m) begin
            wide = {1'b0, a} + {1'b0, b} + {{c_W{1'b0}}, cin};
            co   = wide[c_W];
            f    = (wide >= {1'b0, c});
            wide = f ? (wide - {1'b0, c}) : wide;
            res  = wide[c_W-1:0];
        end else begin
            co  = ({1'b0, a} < ({1'b0, b} + {{c_W{1'b0}}, cin}));
            f   = co;
            res = a - b - {{(c_W-1){1'b0}}, cin};
            if (f) res = res + c;
        end
    endfunction

    task automatic issue_start(input logic m, input logic cin);
        @(negedge clk);
        start    = 1'b1;
        mode     = m;
        carry_in = cin;
    endtask

    // Feeds one operation (start already driven) and checks the output timing.
    // chain_nxt: drive the next start in the done cycle.
    task automatic feed(input string name, input logic m, input logic cin,
                        input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                        input logic [c_W-1:0] c, input bit gaps,
                        input bit extra_start, input bit chain_nxt,
                        input logic nxt_m, input logic nxt_cin);
        logic [c_W-1:0] res;
        logic           ef;
        logic           eco;
        model(m, cin, a, b, c, res, ef, eco);
        for (int i = 0; i < DIGITS; i++) exp_q.push_back(res[i*RADIX +: RADIX]);
        for (int i = 0; i < DIGITS; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 3);
                repeat (g) begin
                    digit_in_valid = 1'b0;
                    digit_a        = 8'hA5;
                    digit_b        = 8'h5A;
                    digit_const    = 8'h3C;
                    @(negedge clk);
                end
            end
            digit_in_valid = 1'b1;
            digit_a        = a[i*RADIX +: RADIX];
            digit_b        = b[i*RADIX +: RADIX];
            digit_const    = c[i*RADIX +: RADIX];
            if (extra_start && i == 1) begin
                start = 1'b1;
                mode  = ~m;
            end
        end
        @(negedge clk);
        start          = 1'b0;
        digit_in_valid = 1'b0;
        n_checks++;
        if (digit_out_valid !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s select_cycle: valid=%b done=%b, expected 0 0", name, digit_out_valid, done);
        end
        for (int j = 0; j < DIGITS; j++) begin
            @(negedge clk);
            n_checks++;
            if (digit_out_valid !== 1'b1 || done !== 1'b0 || flag !== ef || carry_out !== eco) begin
                n_errors++;
                $display("FAIL %s out_cycle%0d: valid=%b done=%b flag=%b co=%b, expected 1 0 %b %b",
                         name, j, digit_out_valid, done, flag, carry_out, ef, eco);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || digit_out_valid !== 1'b0 || flag !== ef || carry_out !== eco) begin
            n_errors++;
            $display("FAIL %s done_cycle: done=%b valid=%b flag=%b co=%b, expected 1 0 %b %b",
                     name, done, digit_out_valid, flag, carry_out, ef, eco);
        end
        if (chain_nxt) begin
            start    = 1'b1;
            mode     = nxt_m;
            carry_in = nxt_cin;
        end else begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) begin
                n_errors++;
                $display("FAIL %s done_pulse_width: done=%b, expected 0", name, done);
            end
        end
    endtask

    task automatic run_op(input string name, input logic m, input logic cin,
                          input logic [c_W-1:0] a, input logic [c_W-1:0] b,
                          input logic [c_W-1:0] c, input bit gaps, input bit extra_start);
        issue_start(m, cin);
        feed(name, m, cin, a, b, c, gaps, extra_start, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst            = 1'b1;
        start          = 1'b0;
        mode           = 1'b0;
        carry_in       = 1'b0;
        digit_in_valid = 1'b0;
        digit_a        = '0;
        digit_b        = '0;
        digit_const    = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (digit_out_valid !== 1'b0 || digit_res !== 8'h00 || flag !== 1'b0 ||
            carry_out !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: valid=%b res=%02h flag=%b co=%b done=%b, expected all 0",
                     digit_out_valid, digit_res, flag, carry_out, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_add;
        run_op("add_small",  1'b0, 1'b0, 32'h00000001, 32'h00000002, 32'h00000010, 1'b0, 1'b0);
        run_op("add_equal",  1'b0, 1'b0, 32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 1'b0);
        run_op("add_wrap",   1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0);
        run_op("add_cin",    1'b0, 1'b1, 32'h0000000F, 32'h00000000, 32'h00000010, 1'b0, 1'b0);
    endtask

    task automatic test_sub;
        run_op("sub_neg",    1'b1, 1'b0, 32'h00000005, 32'h00000007, 32'h00000010, 1'b0, 1'b0);
        run_op("sub_pos",    1'b1, 1'b0, 32'h00000007, 32'h00000005, 32'h00000010, 1'b0, 1'b0);
        run_op("sub_bin",    1'b1, 1'b1, 32'h00000005, 32'h00000005, 32'h00000010, 1'b0, 1'b0);
    endtask

    // Valid digits while IDLE must not be consumed.
    task automatic test_idle_valid;
        @(negedge clk);
        digit_in_valid = 1'b1;
        digit_a        = 8'hFF;
        digit_b        = 8'hFF;
        digit_const    = 8'h01;
        repeat (3) @(negedge clk);
        digit_in_valid = 1'b0;
        n_checks++;
        if (digit_out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_valid: valid=%b, expected 0", digit_out_valid);
        end
        run_op("after_idle_valid", 1'b0, 1'b0, 32'h00000001, 32'h00000002, 32'h00000010, 1'b0, 1'b0);
    endtask

    task automatic test_gaps;
        run_op("gaps_restart", 1'b0, 1'b0, 32'h00000001, 32'h00000002, 32'h00000010, 1'b1, 1'b1);
        run_op("gaps_sub",     1'b1, 1'b0, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_out;
        int bad;
        logic [c_W-1:0] res;
        logic ef, eco;
        issue_start(1'b0, 1'b0);
        model(1'b0, 1'b0, 32'h11223344, 32'h01010101, 32'h20000000, res, ef, eco);
        for (int i = 0; i < DIGITS; i++) exp_q.push_back(res[i*RADIX +: RADIX]);
        for (int i = 0; i < DIGITS; i++) begin
            @(negedge clk);
            start          = 1'b0;
            digit_in_valid = 1'b1;
            digit_a        = 8'h44 - 8'(i * 8'h11);
            digit_b        = 8'h01;
            digit_const    = (i == 3) ? 8'h20 : 8'h00;
        end
        @(negedge clk);
        digit_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (digit_out_valid !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_out: valid=%b done=%b, expected 0 0", digit_out_valid, done);
        end
        bad = 0;
        repeat (DIGITS + 4) begin
            @(negedge clk);
            if (done !== 1'b0 || digit_out_valid !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL rst_no_done: %0d cycles with done/valid set, expected 0", bad);
        end
        run_op("add_equal_after_rst", 1'b0, 1'b0, 32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 1'b0);
    endtask

    // Operations chained with start in each done cycle.
    task automatic test_back_to_back;
        logic [c_W-1:0] a [4];
        logic [c_W-1:0] b [4];
        logic [c_W-1:0] c [4];
        logic           m [5];
        logic           ci[5];
        for (int i = 0; i < 4; i++) begin
            a[i]  = $urandom;
            b[i]  = $urandom;
            c[i]  = $urandom;
            m[i]  = 1'($urandom_range(0, 1));
            ci[i] = 1'($urandom_range(0, 1));
        end
        m[4]  = 1'b0;
        ci[4] = 1'b0;
        issue_start(m[0], ci[0]);
        for (int i = 0; i < 4; i++) begin
            feed($sformatf("b2b%0d", i), m[i], ci[i], a[i], b[i], c[i], 1'b0, 1'b0,
                 (i < 3), m[i+1], ci[i+1]);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_idle_valid();
        test_gaps();
        test_reset_mid_out();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover_digits: %0d expected digits never produced, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
